spiral_pattern_gen: RTL and testbench

Parametrised successor to the fixed 6-arm rotating spiral generator in the pattern bank. It adds a configurable arm count, centre, radius scaling and accumulator width. Direction reversal is smooth, via a decel/accel state machine, and palette rotation is optional. It sits beside the other pattern generators, takes the VGA timing core's x/y/active/next_frame, and drives a registered 6-bit RGB (2:2:2) into the pattern mux.

---
 rtl/spiral_pattern_if.sv | 29 ++
 rtl/spiral_pattern_gen.sv | 142 ++++++++++++++
 tb/tb_spiral_pattern_gen.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spiral_pattern_if.sv
// Pixel/frame bus between the VGA timing core, the spiral generator and the pattern mux.
// Strobe semantics: next_frame is a one-cycle pulse, acted on only when pattern_enable is high; there is no backpressure.
interface spiral_pattern_if #(
   parameter int ROT_W = 6
);
   logic             pattern_enable;
   logic [9:0]       x;
   logic [9:0]       y;
   logic             active;
   logic             next_frame;
   logic [2:0]       step_size;
   logic             dir_req;
   logic [5:0]       rgb;
   logic             dir_out;
   logic             busy;
   logic [1:0]       state_dbg;
   logic [ROT_W+1:0] phase_dbg;
   logic [2:0]       speed_dbg;

   modport master (
      output pattern_enable, x, y, active, next_frame, step_size, dir_req,
      input  rgb, dir_out, busy, state_dbg, phase_dbg, speed_dbg
   );

   modport slave (
      input  pattern_enable, x, y, active, next_frame, step_size, dir_req,
      output rgb, dir_out, busy, state_dbg, phase_dbg, speed_dbg
   );
endinterface

// File: rtl/spiral_pattern_gen.sv
// Rotating multi-arm spiral with smooth decel/accel direction reversal.
// Optional palette rotation is enabled by defining SPIRAL_PALETTE_CYCLE_EN.
module spiral_pattern_gen #(
   parameter int ARMS         = 6,
   parameter int ROT_W        = 6,
   parameter int RADIUS_SHIFT = 4,
   parameter int CENTER_X     = 320,
   parameter int CENTER_Y     = 240,
   parameter int MIN_RADIUS   = 20,
   parameter int PAL_DIV      = 5
) (
   input logic             clk,
   input logic             rst,
   spiral_pattern_if.slave bus
);
   localparam int PW  = ROT_W + 2;
   localparam int SPW = ROT_W + 1;
   localparam logic [9:0] CX = 10'(CENTER_X);
   localparam logic [9:0] CY = 10'(CENTER_Y);
   localparam logic [9:0] MIN_R = 10'(MIN_RADIUS);
   localparam logic [3:0] ARMS4 = 4'(ARMS);

   if (ARMS < 2 || ARMS > 8 || ROT_W < 4 || ROT_W > 8 || PAL_DIV < 1) begin : g_param_check
      $error("spiral_pattern_gen: illegal parameter setting");
   end

   typedef enum logic [1:0] {RUN = 2'd0, DECEL = 2'd1, ACCEL = 2'd2} state_t;

   state_t        state;
   logic [PW-1:0] phase;
   logic [2:0]    speed;
   logic          dir;
   logic          busy_q;
   logic [5:0]    rgb_q;

   wire           tick      = bus.pattern_enable && bus.next_frame;
   wire [PW-1:0]  step_ext  = {{(PW-3){1'b0}}, bus.step_size};
   wire [PW-1:0]  speed_ext = {{(PW-3){1'b0}}, speed};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         phase  <= '0;
         speed  <= '0;
         dir    <= 1'b0;
         busy_q <= 1'b0;
      end else if (tick) begin
         case (state)
            RUN: begin
               phase <= dir ? phase - step_ext : phase + step_ext;
               // Deceleration begins on the request tick itself, so the first DECEL step is one below cruise.
               if (bus.dir_req != dir) begin
                  state  <= DECEL;
                  busy_q <= 1'b1;
                  speed  <= (bus.step_size == 3'd0) ? 3'd0 : bus.step_size - 3'd1;
               end else begin
                  speed <= bus.step_size;
               end
            end
            DECEL: begin
               if (speed == 3'd0) begin
                  dir   <= ~dir;
                  state <= ACCEL;
               end else begin
                  phase <= dir ? phase - speed_ext : phase + speed_ext;
                  if (bus.dir_req == dir) state <= ACCEL;
                  else                    speed <= speed - 3'd1;
               end
            end
            ACCEL: begin
               phase <= dir ? phase - speed_ext : phase + speed_ext;
               if ({1'b0, speed} + 4'd1 >= {1'b0, bus.step_size}) begin
                  speed  <= bus.step_size;
                  state  <= RUN;
                  busy_q <= 1'b0;
               end else begin
                  speed <= speed + 3'd1;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

   logic [2:0] pal_off;
`ifdef SPIRAL_PALETTE_CYCLE_EN
   logic [PAL_DIV-1:0] frame_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_cnt <= '0;
         pal_off   <= '0;
      end else if (tick) begin
         frame_cnt <= frame_cnt + PAL_DIV'(1);
         if (&frame_cnt) pal_off <= (pal_off == 3'(ARMS - 1)) ? 3'd0 : pal_off + 3'd1;
      end
   end
`else
   assign pal_off = 3'd0;
`endif

   // Pixel path: sector-based coarse angle, twisted by radius to form the spiral arms.
   wire           x_ge   = bus.x >= CX;
   wire           y_ge   = bus.y >= CY;
   wire [9:0]     dx     = x_ge ? bus.x - CX : CX - bus.x;
   wire [9:0]     dy     = y_ge ? bus.y - CY : CY - bus.y;
   wire [9:0]     radius = dx + dy;
   wire [2:0]     sector = {x_ge, y_ge, dx > dy};
   wire [ROT_W-1:0] rot   = phase[PW-1:2];
   wire [ROT_W-1:0] angle = {sector, {(ROT_W-3){1'b0}}} + rot;
   wire [SPW-1:0] sp     = {1'b0, angle} - SPW'(radius >> RADIUS_SHIFT);
   wire [2:0]     arm    = sp[ROT_W:ROT_W-2];
   wire           in_arm = !sp[ROT_W-3] && ({1'b0, arm} < ARMS4) && (radius > MIN_R);
   wire [3:0]     csum   = {1'b0, arm} + {1'b0, pal_off};
   wire [3:0]     cidx   = (csum >= ARMS4) ? csum - ARMS4 : csum;

   function automatic logic [5:0] pal_color(input logic [3:0] idx);
      case (idx)
         4'd0:    pal_color = 6'b010001;
         4'd1:    pal_color = 6'b100011;
         4'd2:    pal_color = 6'b111010;
         4'd3:    pal_color = 6'b001110;
         4'd4:    pal_color = 6'b011101;
         4'd5:    pal_color = 6'b101111;
         4'd6:    pal_color = 6'b110000;
         4'd7:    pal_color = 6'b000111;
         default: pal_color = 6'b000000;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rgb_q <= '0;
      else     rgb_q <= (bus.active && in_arm) ? pal_color(cidx) : 6'b000000;
   end

   assign bus.rgb       = rgb_q;
   assign bus.dir_out   = dir;
   assign bus.busy      = busy_q;
   assign bus.state_dbg = state;
   assign bus.phase_dbg = phase;
   assign bus.speed_dbg = speed;
endmodule

// File: tb/tb_spiral_pattern_gen.sv
// Self-checking bench for spiral_pattern_gen: reversal profile, pixel colours, hold, async reset, palette.
module tb_spiral_pattern_gen;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   spiral_pattern_if bus ();

   spiral_pattern_gen dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [5:0] exp_q[$];
   int total = 0;
   int bad   = 0;
   int cur_rot = 0;

   localparam logic [1:0] S_RUN = 2'd0, S_DECEL = 2'd1, S_ACCEL = 2'd2;
   localparam logic [5:0] PAL_TAB [0:7] = '{6'b010001, 6'b100011, 6'b111010, 6'b001110,
                                            6'b011101, 6'b101111, 6'b110000, 6'b000111};

   // Independent reference for the pixel colour, written in plain integer arithmetic.
   function automatic logic [5:0] model_rgb(int px, int py, int act, int rot, int pal);
      int dx, dy, r, sec, ang, sp, arm, b3;
      dx  = (px >= 320) ? px - 320 : 320 - px;
      dy  = (py >= 240) ? py - 240 : 240 - py;
      r   = (dx + dy) % 1024;
      sec = ((px >= 320) ? 4 : 0) + ((py >= 240) ? 2 : 0) + ((dx > dy) ? 1 : 0);
      ang = (sec * 8 + rot) % 64;
      sp  = (((ang - (r / 16)) % 128) + 128) % 128;
      arm = sp / 16;
      b3  = (sp / 8) % 2;
      if (act == 0 || b3 != 0 || arm >= 6 || r <= 20) return 6'b000000;
      return PAL_TAB[(arm + pal) % 6];
   endfunction

   task automatic apply_reset();
      bus.pattern_enable = 1'b1;
      bus.next_frame = 1'b0;
      bus.x = 10'd0;
      bus.y = 10'd0;
      bus.active = 1'b0;
      bus.step_size = 3'd0;
      bus.dir_req = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic do_tick();
      bus.next_frame = 1'b1;
      @(posedge clk);
      #1 bus.next_frame = 1'b0;
   endtask

   task automatic pixel_step(int px, int py, int act, logic [5:0] exp);
      logic [5:0] want;
      bus.x = 10'(px);
      bus.y = 10'(py);
      bus.active = act[0];
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      total++;
      if (bus.rgb !== want) begin
         bad++;
         $display("FAIL rgb(%0d,%0d,a=%0d): got %b want %b", px, py, act, bus.rgb, want);
      end
   endtask

   task automatic pixel_random(int n, int pal);
      for (int i = 0; i < n; i++) begin
         int px, py, act;
         px  = $urandom_range(0, 639);
         py  = $urandom_range(0, 479);
         act = ($urandom_range(0, 3) != 0) ? 1 : 0;
         pixel_step(px, py, act, model_rgb(px, py, act, cur_rot, pal));
      end
   endtask

   task automatic test_reset();
      total++;
      if (bus.rgb !== 6'd0) begin bad++; $display("FAIL reset_rgb: got %b want 000000", bus.rgb); end
      total++;
      if (bus.dir_out !== 1'b0) begin bad++; $display("FAIL reset_dir: got %b want 0", bus.dir_out); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      total++;
      if (bus.phase_dbg !== 8'd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", bus.phase_dbg); end
      total++;
      if (bus.state_dbg !== S_RUN) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.state_dbg); end
   endtask

   task automatic test_run();
      bus.step_size = 3'd4;
      repeat (4) do_tick();
      total++;
      if (bus.phase_dbg !== 8'd16) begin bad++; $display("FAIL run_phase: got %0d want 16", bus.phase_dbg); end
      total++;
      if (bus.busy !== 1'b0 || bus.dir_out !== 1'b0) begin
         bad++; $display("FAIL run_flags: got busy=%b dir=%b want 0 0", bus.busy, bus.dir_out);
      end
      cur_rot = 4;
      pixel_random(24, 0);
   endtask

   task automatic test_reverse();
      int exp_phase [10] = '{20, 23, 25, 26, 26, 26, 25, 23, 20, 16};
      bit exp_dir   [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
      bit exp_busy  [10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
      bus.dir_req = 1'b1;
      for (int t = 0; t < 10; t++) begin
         do_tick();
         total++;
         if (bus.phase_dbg !== 8'(exp_phase[t]) || bus.dir_out !== exp_dir[t] || bus.busy !== exp_busy[t]) begin
            bad++;
            $display("FAIL reverse_tick%0d: got phase=%0d dir=%b busy=%b want phase=%0d dir=%b busy=%b",
                     t + 1, bus.phase_dbg, bus.dir_out, bus.busy, exp_phase[t], exp_dir[t], exp_busy[t]);
         end
      end
   endtask

   task automatic test_pixels();
      apply_reset();
      cur_rot = 0;
      pixel_step(400, 240, 1, 6'b001110);
      pixel_step(400, 240, 0, 6'b000000);
      pixel_step(320, 240, 1, 6'b000000);
      pixel_step(160, 240, 1, model_rgb(160, 240, 1, 0, 0));
      pixel_random(40, 0);
   endtask

   task automatic test_withdraw();
      apply_reset();
      bus.step_size = 3'd4;
      repeat (2) do_tick();
      bus.dir_req = 1'b1;
      repeat (2) do_tick();
      total++;
      if (bus.state_dbg !== S_DECEL || bus.speed_dbg !== 3'd2 || bus.phase_dbg !== 8'd15) begin
         bad++;
         $display("FAIL withdraw_decel: got state=%0d speed=%0d phase=%0d want 1 2 15",
                  bus.state_dbg, bus.speed_dbg, bus.phase_dbg);
      end
      bus.dir_req = 1'b0;
      do_tick();
      total++;
      if (bus.state_dbg !== S_ACCEL || bus.dir_out !== 1'b0 || bus.phase_dbg !== 8'd17) begin
         bad++;
         $display("FAIL withdraw_accel: got state=%0d dir=%b phase=%0d want 2 0 17",
                  bus.state_dbg, bus.dir_out, bus.phase_dbg);
      end
      repeat (2) do_tick();
      total++;
      if (bus.state_dbg !== S_RUN || bus.speed_dbg !== 3'd4 || bus.busy !== 1'b0 ||
          bus.dir_out !== 1'b0 || bus.phase_dbg !== 8'd22) begin
         bad++;
         $display("FAIL withdraw_run: got state=%0d speed=%0d busy=%b dir=%b phase=%0d want 0 4 0 0 22",
                  bus.state_dbg, bus.speed_dbg, bus.busy, bus.dir_out, bus.phase_dbg);
      end
   endtask

   task automatic test_hold_and_async_reset();
      bus.dir_req = 1'b1;
      repeat (6) do_tick();
      bus.pattern_enable = 1'b0;
      repeat (10) begin
         do_tick();
         @(posedge clk);
         #1;
      end
      total++;
      if (bus.phase_dbg !== 8'd32 || bus.speed_dbg !== 3'd1 || bus.state_dbg !== S_ACCEL ||
          bus.dir_out !== 1'b1 || bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL hold: got phase=%0d speed=%0d state=%0d dir=%b busy=%b want 32 1 2 1 1",
                  bus.phase_dbg, bus.speed_dbg, bus.state_dbg, bus.dir_out, bus.busy);
      end
      bus.pattern_enable = 1'b1;
      cur_rot = 8;
      pixel_step(160, 240, 1, model_rgb(160, 240, 1, 8, 0));
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (bus.rgb !== 6'd0 || bus.dir_out !== 1'b0 || bus.busy !== 1'b0 ||
          bus.phase_dbg !== 8'd0 || bus.speed_dbg !== 3'd0 || bus.state_dbg !== S_RUN) begin
         bad++;
         $display("FAIL async_reset: got rgb=%b dir=%b busy=%b phase=%0d speed=%0d state=%0d want all 0",
                  bus.rgb, bus.dir_out, bus.busy, bus.phase_dbg, bus.speed_dbg, bus.state_dbg);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_palette();
      int ticks = 0;
      int pal;
      apply_reset();
      bus.x = 10'd400;
      bus.y = 10'd240;
      bus.active = 1'b1;
      for (int round = 0; round < 2; round++) begin
         int n;
         n = (round == 0) ? 32 : 160;
         repeat (n) do_tick();
         ticks += n;
`ifdef SPIRAL_PALETTE_CYCLE_EN
         pal = (ticks / 32) % 6;
`else
         pal = 0;
`endif
         pixel_step(400, 240, 1, model_rgb(400, 240, 1, 0, pal));
      end
   endtask

   initial begin
      apply_reset();
      test_reset();
      test_run();
      test_reverse();
      test_pixels();
      test_withdraw();
      test_hold_and_async_reset();
      test_palette();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
